// File: rtl/regfile_dump_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// regfile_dump_ctrl_pkg
// Shared definitions for the register-file dump sequencer:
//   - state_t          : FSM state encoding (HEADER is only reachable when the
//                        design is built with REGFILE_DUMP_HEADER_EN defined)
//   - DUMP_HEADER_BYTE : sync byte sent ahead of the register stream
//   - bytes_per_word   : helper giving how many bytes make up one word
// -----------------------------------------------------------------------------
package regfile_dump_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_READ    = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_SEND    = 3'd3,
      ST_DONE    = 3'd4,
      ST_HEADER  = 3'd5
   } state_t;

   localparam logic [7:0] DUMP_HEADER_BYTE = 8'hA5;

   localparam int DEFAULT_LEN     = 32;
   localparam int DEFAULT_NB_BYTE = 8;

   function automatic int bytes_per_word(input int len, input int nb_byte);
      return len / nb_byte;
   endfunction

   localparam int BYTES_PER_WORD = bytes_per_word(DEFAULT_LEN, DEFAULT_NB_BYTE);

endpackage

// File: rtl/regfile_dump_ctrl_word_byte_serializer.sv
// -----------------------------------------------------------------------------
// regfile_dump_ctrl_word_byte_serializer
// Holds one LEN-bit word and presents it MSB byte first. The word is shifted
// left by one byte on every accepted transfer; a down-counter tracks how many
// bytes remain so the controller knows when the last byte is on the output.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        asynchronous active-low reset
//   i_load       load i_load_word / i_load_last (has priority over shift)
//   i_load_word  word to serialise
//   i_load_last  index of the last byte (number of bytes - 1)
//   i_shift      current byte accepted by the sink, advance to the next one
//   o_byte       current byte (MSB byte of the shift register)
//   o_last       current byte is the last one of the loaded word
// -----------------------------------------------------------------------------
module regfile_dump_ctrl_word_byte_serializer #(
   parameter int LEN     = 32,
   parameter int NB_BYTE = 8,
   parameter int CNT_W   = 2
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_load,
   input  logic [LEN-1:0]     i_load_word,
   input  logic [CNT_W-1:0]   i_load_last,
   input  logic               i_shift,
   output logic [NB_BYTE-1:0] o_byte,
   output logic               o_last
);

   logic [LEN-1:0]   shift_q;
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else if (i_load) begin
         shift_q <= i_load_word;
         cnt_q   <= i_load_last;
      end else if (i_shift) begin
         shift_q <= shift_q << NB_BYTE;
         if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
         end
      end
   end

   assign o_byte = shift_q[LEN-1 -: NB_BYTE];
   assign o_last = (cnt_q == '0);

endmodule

// File: rtl/regfile_dump_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_dump_ctrl
// Debug-side sequencer that freezes the pipeline and streams every
// architectural register, big-endian, as bytes toward the UART transmitter.
// It owns register-file read port 1 and the pipeline enable while busy.
//
// Build option: REGFILE_DUMP_HEADER_EN - when defined, a two-byte header
// (0xA5, then NB_REG) is sent before register 0.
//
// Ports:
//   i_clk            system clock, rising edge
//   i_rst            asynchronous active-low reset
//   i_start          dump request, only looked at in IDLE
//   i_read_data      register file read port 1 data (one cycle after address)
//   i_tx_ready       byte sink can accept
//   o_read_register  register file read port 1 address
//   o_pipe_enable    pipeline enable, low while a dump is in progress
//   o_tx_data        byte toward the sink
//   o_tx_valid       o_tx_data valid
//   o_busy           dump in progress
//   o_done           one-cycle pulse at the end of a dump
//   o_state          current FSM state (debug visibility)
//
// Byte handshake: a byte moves on a rising edge where o_tx_valid and
// i_tx_ready are both 1. Once o_tx_valid is raised it stays high and
// o_tx_data stays constant until that transfer happens. o_tx_valid and
// o_tx_data are decoded from registers only, never from i_tx_ready.
// -----------------------------------------------------------------------------
module regfile_dump_ctrl
   import regfile_dump_ctrl_pkg::*;
#(
   parameter int LEN     = 32,
   parameter int NB_REG  = 32,
   parameter int NB_ADDR = 5,
   parameter int NB_BYTE = 8
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic [LEN-1:0]     i_read_data,
   input  logic               i_tx_ready,
   output logic [NB_ADDR-1:0] o_read_register,
   output logic               o_pipe_enable,
   output logic [NB_BYTE-1:0] o_tx_data,
   output logic               o_tx_valid,
   output logic               o_busy,
   output logic               o_done,
   output logic [2:0]         o_state
);

   localparam int BPW   = bytes_per_word(LEN, NB_BYTE);
   localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [NB_ADDR-1:0] LAST_IDX = NB_ADDR'(NB_REG - 1);

   state_t             state, state_next;
   logic [NB_ADDR-1:0] index;
   logic               index_clr;
   logic               index_inc;
   logic               ser_load;
   logic               ser_shift;
   logic [LEN-1:0]     load_word;
   logic [CNT_W-1:0]   load_last;
   logic               ser_last;
   logic [NB_BYTE-1:0] ser_byte;
   logic               tx_valid;
   logic               xfer;

`ifdef REGFILE_DUMP_HEADER_EN
   // Header bytes occupy the top two byte lanes so the serializer sends them
   // in order with the same handshake as register data.
   logic [LEN-1:0] hdr_word;
   always_comb begin
      hdr_word = '0;
      hdr_word[LEN-1 -: NB_BYTE]         = NB_BYTE'(DUMP_HEADER_BYTE);
      hdr_word[LEN-NB_BYTE-1 -: NB_BYTE] = NB_BYTE'(NB_REG);
   end
   assign tx_valid = (state == ST_SEND) || (state == ST_HEADER);
`else
   assign tx_valid = (state == ST_SEND);
`endif

   assign xfer = tx_valid && i_tx_ready;

   // State register
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and datapath control
   always_comb begin
      state_next = state;
      index_clr  = 1'b0;
      index_inc  = 1'b0;
      ser_load   = 1'b0;
      ser_shift  = 1'b0;
      load_word  = i_read_data;
      load_last  = CNT_W'(BPW - 1);
      case (state)
         ST_IDLE: begin
            if (i_start) begin
               index_clr = 1'b1;
`ifdef REGFILE_DUMP_HEADER_EN
               ser_load   = 1'b1;
               load_word  = hdr_word;
               load_last  = CNT_W'(1);
               state_next = ST_HEADER;
`else
               state_next = ST_READ;
`endif
            end
         end
`ifdef REGFILE_DUMP_HEADER_EN
         ST_HEADER: begin
            if (xfer) begin
               ser_shift = 1'b1;
               if (ser_last) begin
                  state_next = ST_READ;
               end
            end
         end
`endif
         // Address is presented during READ; the register file registers the
         // data on the edge that leaves READ, so it is valid in CAPTURE.
         ST_READ: begin
            state_next = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            ser_load   = 1'b1;
            state_next = ST_SEND;
         end
         ST_SEND: begin
            if (xfer) begin
               ser_shift = 1'b1;
               if (ser_last) begin
                  if (index == LAST_IDX) begin
                     state_next = ST_DONE;
                  end else begin
                     index_inc  = 1'b1;
                     state_next = ST_READ;
                  end
               end
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Register index; stops at the last register, never wraps.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         index <= '0;
      end else if (index_clr) begin
         index <= '0;
      end else if (index_inc) begin
         index <= index + 1'b1;
      end
   end

   regfile_dump_ctrl_word_byte_serializer #(
      .LEN     (LEN),
      .NB_BYTE (NB_BYTE),
      .CNT_W   (CNT_W)
   ) u_serializer (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_load      (ser_load),
      .i_load_word (load_word),
      .i_load_last (load_last),
      .i_shift     (ser_shift),
      .o_byte      (ser_byte),
      .o_last      (ser_last)
   );

   assign o_read_register = index;
   assign o_tx_data       = ser_byte;
   assign o_tx_valid      = tx_valid;
   assign o_busy          = (state != ST_IDLE);
   assign o_pipe_enable   = (state == ST_IDLE);
   assign o_done          = (state == ST_DONE);
   assign o_state         = state;

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
module tb_regfile_dump_ctrl;

   localparam int LEN     = 32;
   localparam int NB_REG  = 32;
   localparam int NB_ADDR = 5;
   localparam int NB_BYTE = 8;

`ifdef REGFILE_DUMP_HEADER_EN
   localparam int EXP_BYTES = 130;
   localparam int EXP_CYC   = 194;
`else
   localparam int EXP_BYTES = 128;
   localparam int EXP_CYC   = 192;
`endif

   // ---------------- clock / reset ----------------
   logic               i_clk = 1'b0;
   logic               i_rst;
   logic               i_start;
   logic [LEN-1:0]     i_read_data;
   logic               i_tx_ready;
   logic [NB_ADDR-1:0] o_read_register;
   logic               o_pipe_enable;
   logic [NB_BYTE-1:0] o_tx_data;
   logic               o_tx_valid;
   logic               o_busy;
   logic               o_done;
   logic [2:0]         o_state;

   always #5 i_clk = ~i_clk;

   regfile_dump_ctrl #(
      .LEN(LEN), .NB_REG(NB_REG), .NB_ADDR(NB_ADDR), .NB_BYTE(NB_BYTE)
   ) dut (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .i_start         (i_start),
      .i_read_data     (i_read_data),
      .i_tx_ready      (i_tx_ready),
      .o_read_register (o_read_register),
      .o_pipe_enable   (o_pipe_enable),
      .o_tx_data       (o_tx_data),
      .o_tx_valid      (o_tx_valid),
      .o_busy          (o_busy),
      .o_done          (o_done),
      .o_state         (o_state)
   );

   // ---------------- register file model ----------------
   logic [LEN-1:0] regs [NB_REG];
   initial begin
      for (int i = 0; i < NB_REG; i++) regs[i] = 32'h0102_0300 + i;
   end
   always @(posedge i_clk) i_read_data <= regs[o_read_register];

   // ---------------- sink ready driver ----------------
   int rdy_mode = 0;   // 0: always ready, 1: toggle 1010...
   always @(posedge i_clk) begin
      #1;
      if (rdy_mode == 0) i_tx_ready = 1'b1;
      else               i_tx_ready = ~i_tx_ready;
   end

   // ---------------- checking ----------------
   int chk_cnt = 0;
   int err_cnt = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- scoreboard / monitor ----------------
   logic [7:0] exp_q[$];
   int cyc = 0;
   always @(posedge i_clk) cyc++;

   bit         mon_en = 0;
   bit         first_busy;
   bit         stall_pending;
   bit         prev_done;
   logic [7:0] stall_data;
   int         start_cyc, done_cyc;
   int         byte_cnt, done_cnt, bad_pipe;

   always @(negedge i_clk) begin
      if (o_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (mon_en) begin
         if (o_busy && first_busy) begin
            start_cyc  = cyc;
            first_busy = 0;
         end
         if (o_pipe_enable === o_busy) bad_pipe++;
         if (prev_done) begin
            check("post_done_busy", {31'd0, o_busy}, 32'd0);
            check("post_done_pipe_en", {31'd0, o_pipe_enable}, 32'd1);
         end
         if (stall_pending) begin
            check("stall_valid_held", {31'd0, o_tx_valid}, 32'd1);
            check("stall_data_held", {24'd0, o_tx_data}, {24'd0, stall_data});
         end
         stall_pending = o_tx_valid && !i_tx_ready;
         stall_data    = o_tx_data;
         if (o_tx_valid && i_tx_ready) begin
            byte_cnt++;
            if (exp_q.size() == 0) check("extra_byte", {24'd0, o_tx_data}, 32'hFFFF_FFFF);
            else                   check("byte", {24'd0, o_tx_data}, {24'd0, exp_q.pop_front()});
         end
         prev_done = o_done;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic fill_expected();
      exp_q.delete();
`ifdef REGFILE_DUMP_HEADER_EN
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h20);
`endif
      for (int i = 0; i < NB_REG; i++) begin
         exp_q.push_back(8'h01);
         exp_q.push_back(8'h02);
         exp_q.push_back(8'h03);
         exp_q.push_back(8'(i));
      end
   endtask

   task automatic pulse_start();
      @(posedge i_clk); #1;
      i_start = 1'b1;
      @(posedge i_clk); #1;
      i_start = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rd_reg"}, {27'd0, o_read_register}, 32'd0);
      check({tag, "_tx_data"}, {24'd0, o_tx_data}, 32'd0);
      check({tag, "_tx_valid"}, {31'd0, o_tx_valid}, 32'd0);
      check({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
      check({tag, "_done"}, {31'd0, o_done}, 32'd0);
      check({tag, "_pipe_en"}, {31'd0, o_pipe_enable}, 32'd1);
      check({tag, "_state"}, {29'd0, o_state}, 32'd0);
   endtask

   // mode: ready pattern; restart_at: register index at which i_start is
   // pulsed again mid-dump (-1 for none).
   task automatic run_dump(input int mode, input int restart_at, input bit check_time);
      bit pulsed = 0;
      bit seen   = 0;
      fill_expected();
      rdy_mode      = mode;
      byte_cnt      = 0;
      done_cnt      = 0;
      bad_pipe      = 0;
      first_busy    = 1;
      stall_pending = 0;
      prev_done     = 0;
      mon_en        = 1;
      pulse_start();
      for (int n = 0; n < 3000; n++) begin
         @(negedge i_clk);
         if (o_done) begin
            seen = 1;
            break;
         end
         if (restart_at >= 0 && !pulsed && o_busy && o_read_register == NB_ADDR'(restart_at)) begin
            pulsed  = 1;
            i_start = 1'b1;
            @(posedge i_clk); #1;
            i_start = 1'b0;
         end
      end
      check("dump_timeout", {31'd0, seen}, 32'd1);
      repeat (4) @(negedge i_clk);
      mon_en = 0;
      check("done_pulses", done_cnt, 32'd1);
      check("byte_count", byte_cnt, EXP_BYTES);
      check("bytes_left", exp_q.size(), 32'd0);
      check("pipe_busy_mismatch_cycles", bad_pipe, 32'd0);
      if (restart_at >= 0) check("restart_seen", {31'd0, pulsed}, 32'd1);
      if (check_time) check("done_latency", done_cyc - start_cyc, EXP_CYC);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      i_rst      = 1'b0;
      i_start    = 1'b0;
      i_tx_ready = 1'b1;
      repeat (3) @(posedge i_clk);
      #1;
      check_reset_outputs("reset");
      i_rst = 1'b1;
      repeat (2) @(negedge i_clk);
      check_reset_outputs("idle");

      // Full dump, sink always ready, with cycle-exact timing.
      run_dump(0, -1, 1'b1);

      // Sink ready toggling: same stream, data held across stalls.
      run_dump(1, -1, 1'b0);

      // Second start pulse during register 12 must be ignored.
      run_dump(0, 12, 1'b1);

      // Reset in the middle of sending register 7.
      begin
         bit found = 0;
         int done_before;
         fill_expected();
         rdy_mode = 0;
         pulse_start();
         for (int n = 0; n < 2000; n++) begin
            @(negedge i_clk);
            if (o_tx_valid && o_read_register == NB_ADDR'(7)) begin
               found = 1;
               break;
            end
         end
         check("find_reg7_send", {31'd0, found}, 32'd1);
         done_before = done_cnt;
         #2;
         i_rst = 1'b0;
         #1;
         check_reset_outputs("mid_reset");
         repeat (3) @(posedge i_clk);
         #1;
         i_rst = 1'b1;
         repeat (4) @(negedge i_clk);
         check_reset_outputs("after_abort");
         check("abort_no_done", done_cnt, done_before);
      end

      // Recovery: a clean dump after the abort.
      run_dump(0, -1, 1'b1);

      $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/regfile_dump_ctrl.md
# regfile_dump_ctrl

Debug-side sequencer for the MIPS register file. On a start request it freezes the pipeline, walks every architectural register through the register file's synchronous read port 1, and streams each word out as bytes over a valid/ready byte interface toward the UART transmitter. It sits between the debug unit and the ID-stage register file, owning read port 1 and the pipeline enable while a dump is active.

## Interface
- LEN, 32, register width in bits; multiple of 8
- NB_REG, 32, number of registers dumped
- NB_ADDR, 5, register address width
- NB_BYTE, 8, output byte width
- i_clk  in  1  system clock, rising edge
- i_rst  in  1  asynchronous, active-low reset
- i_start  in  1  dump request; sampled only in IDLE
- i_read_data  in  LEN  register file read port 1 data (registered, valid one cycle after address edge)
- i_tx_ready  in  1  byte sink can accept
- o_read_register  out  NB_ADDR  address to register file read port 1
- o_pipe_enable  out  1  pipeline enable; low while busy
- o_tx_data  out  NB_BYTE  byte to sink
- o_tx_valid  out  1  o_tx_data valid
- o_busy  out  1  dump in progress
- o_done  out  1  one-cycle pulse at dump end

## Operation
- States: IDLE, READ, CAPTURE, SEND, DONE (plus HEADER with macro).
- IDLE: o_pipe_enable=1, o_busy=0. i_start=1 -> READ, reg index cleared to 0.
- READ: o_read_register=index; register file latches data on the closing edge.
- CAPTURE: i_read_data loaded into LEN-bit shift register; byte counter = LEN/8-1 -> SEND.
- SEND: o_tx_data = shift register MSB byte (big-endian word order); o_tx_valid=1. On valid&&ready: shift left by NB_BYTE; if byte counter 0 -> (index==NB_REG-1 ? DONE : index+1, READ), else decrement.
- DONE: o_done=1 for one cycle, -> IDLE; o_busy drops in the IDLE cycle.
- o_busy=1 and o_pipe_enable=0 in every non-IDLE state; pipeline therefore does not write the register file mid-dump.
- i_start while busy: ignored, no queuing. i_start held high through DONE: a new dump starts from IDLE the following cycle.
- Index counter NB_ADDR wide; no wrap past NB_REG-1.

## Timing
- Reset (async, i_rst=0): state IDLE, index 0, o_read_register 0, o_tx_data 0, o_tx_valid 0, o_busy 0, o_done 0, o_pipe_enable 1, shift register 0.
- Reset mid-dump aborts immediately; partial byte dropped, no o_done.
- i_start high at edge N -> o_busy/o_pipe_enable change at N+1; first o_tx_valid at N+3.
- o_tx_data stable while o_tx_valid=1 and i_tx_ready=0; o_tx_valid never drops without a transfer.
- i_tx_ready permanently 1: 2+LEN/8 cycles per register; default dump = 192 cycles from READ to DONE.
- i_tx_ready is not combinationally fed to any output.

## Configuration
- REGFILE_DUMP_HEADER_EN defined: IDLE -> HEADER first; sends 0xA5 then NB_REG (low NB_BYTE bits) with same handshake, then READ. Dump is 2 bytes longer.
- Undefined: no HEADER state; IDLE -> READ directly; first byte is register 0 MSB.

## Structure
- Shared package: state encoding, DUMP_HEADER_BYTE = 8'hA5, BYTES_PER_WORD = LEN/NB_BYTE.
- One sub-module: word_byte_serializer (load, shift on handshake, last-byte flag); FSM and index counter in top.

## Test plan
- Reset asserted mid-SEND of register 7 -> all outputs at reset values same cycle; o_done never pulses.
- Registers preloaded r[i]=0x01020300+i, ready always 1, pulse i_start -> 128 bytes 01,02,03,00,01,02,03,01,..., o_done exactly 192 cycles after READ entry.
- ready toggling 1010... -> identical byte stream, o_tx_data constant across every stalled cycle.
- i_start pulsed again during register 12 -> ignored; single o_done; byte count 128.
- REGFILE_DUMP_HEADER_EN defined -> first bytes A5, 20 then register 0 data; 130 bytes total.
- During whole dump o_pipe_enable=0 and o_busy=1; both restored exactly one cycle after o_done.
